// File: rtl/ahb_bus_fabric.sv
// Two-master, three-slave single-transfer AHB-style interconnect.
// Fixed-priority arbiter FSM, registered address with slave decode, and data/response muxing.
module ahb_bus_fabric #(
  parameter int AW = 16,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          busreq_1,
  input  logic          busreq_2,
  input  logic          read_write,
  input  logic          ready,
  input  logic [1:0]    response,
  input  logic          split,
  input  logic [AW-1:0] data_in1,
  input  logic [AW-1:0] data_in2,
  input  logic [DW-1:0] data_in3,
  input  logic [DW-1:0] data_in4,
  input  logic [DW-1:0] rdin1,
  input  logic [DW-1:0] rdin2,
  input  logic [DW-1:0] rdin3,
  input  logic [1:0]    resp1,
  input  logic [1:0]    resp2,
  input  logic [1:0]    resp3,
  input  logic          rdy1,
  input  logic          rdy2,
  input  logic          rdy3,
  output logic          grant_1,
  output logic          grant_2,
  output logic [AW-1:0] address,
  output logic          slave_0,
  output logic          slave_1,
  output logic          slave_2,
  output logic [DW-1:0] dataout,
  output logic [DW-1:0] dout,
  output logic [1:0]    respout,
  output logic          rdyout,
  output logic          Aout,
  output logic          Dout
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] ADDR  = 2'd2;
  localparam logic [1:0] DATA  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic          owner_q, owner_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          mask1_q, mask1_d;
  logic          mask2_q, mask2_d;
  logic [2:0]    sel_raw;
  logic          in_phase;

  // The address register is loaded on every entry into ADDR so the address is valid throughout ADDR.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    mask1_d = mask1_q;
    mask2_d = mask2_q;
    case (state_q)
      IDLE: begin
        if (busreq_1 && !mask1_q) begin
          owner_d = 1'b0;
          state_d = GRANT;
        end else if (busreq_2 && !mask2_q) begin
          owner_d = 1'b1;
          state_d = GRANT;
        end
      end
      GRANT: begin
        state_d = ADDR;
        addr_d  = owner_q ? data_in2 : data_in1;
      end
      ADDR: state_d = DATA;
      DATA: begin
        if (ready) begin
          case (response)
            2'b10: begin
              state_d = ADDR;
              addr_d  = owner_q ? data_in2 : data_in1;
            end
            2'b11: begin
              state_d = IDLE;
              if (owner_q) mask2_d = 1'b1;
              else         mask1_d = 1'b1;
            end
            default: state_d = IDLE;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
    if (split) begin
      mask1_d = 1'b0;
      mask2_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      addr_q  <= '0;
      mask1_q <= 1'b0;
      mask2_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      mask1_q <= mask1_d;
      mask2_q <= mask2_d;
    end
  end

  always_comb begin
    in_phase = (state_q == ADDR) || (state_q == DATA);
    case (addr_q[AW-1 -: 3])
      3'b001:  sel_raw = 3'b001;
      3'b010:  sel_raw = 3'b010;
      3'b011:  sel_raw = 3'b100;
      default: sel_raw = 3'b000;
    endcase
    grant_1 = (state_q != IDLE) && !owner_q;
    grant_2 = (state_q != IDLE) && owner_q;
    Aout    = in_phase;
    Dout    = (state_q == DATA) && read_write;
    dataout = Dout ? (owner_q ? data_in4 : data_in3) : '0;
    address = in_phase ? addr_q : '0;
    slave_0 = in_phase && sel_raw[0];
    slave_1 = in_phase && sel_raw[1];
    slave_2 = in_phase && sel_raw[2];
  end

  // Read path follows the internal decode; the idle default ready is suppressed while reset is held.
  always_comb begin
    dout    = '0;
    respout = 2'b00;
    rdyout  = 1'b1;
    case (sel_raw)
      3'b001: begin dout = rdin1; respout = resp1; rdyout = rdy1; end
      3'b010: begin dout = rdin2; respout = resp2; rdyout = rdy2; end
      3'b100: begin dout = rdin3; respout = resp3; rdyout = rdy3; end
      default: ;
    endcase
    if (rst) begin
      dout    = '0;
      respout = 2'b00;
      rdyout  = 1'b0;
    end
  end

endmodule

// File: tb/tb_ahb_bus_fabric.sv
// Directed, table-driven bench for ahb_bus_fabric plus hand sequences for wait, retry, split and reset.
module tb_ahb_bus_fabric;

  logic        clk, rst;
  logic        busreq_1, busreq_2, read_write, ready, split;
  logic [1:0]  response;
  logic [15:0] data_in1, data_in2;
  logic [31:0] data_in3, data_in4, rdin1, rdin2, rdin3;
  logic [1:0]  resp1, resp2, resp3;
  logic        rdy1, rdy2, rdy3;
  logic        grant_1, grant_2, slave_0, slave_1, slave_2, rdyout, Aout, Dout;
  logic [15:0] address;
  logic [31:0] dataout, dout;
  logic [1:0]  respout;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        req1, req2, rw, rdy_in;
    logic [1:0]  resp_in;
    logic        g1, g2;
    logic [15:0] addr;
    logic [2:0]  sel;
    logic        aout, den;
    logic [31:0] wdata;
    logic        chk_rd;
    logic [31:0] rd;
    logic [1:0]  rresp;
    logic        rrdy;
  } vec_t;

  vec_t vecs [12];
  vec_t zero_v;

  ahb_bus_fabric #(.AW(16), .DW(32)) dut (
    .clk(clk), .rst(rst), .busreq_1(busreq_1), .busreq_2(busreq_2),
    .read_write(read_write), .ready(ready), .response(response), .split(split),
    .data_in1(data_in1), .data_in2(data_in2), .data_in3(data_in3), .data_in4(data_in4),
    .rdin1(rdin1), .rdin2(rdin2), .rdin3(rdin3),
    .resp1(resp1), .resp2(resp2), .resp3(resp3),
    .rdy1(rdy1), .rdy2(rdy2), .rdy3(rdy3),
    .grant_1(grant_1), .grant_2(grant_2), .address(address),
    .slave_0(slave_0), .slave_1(slave_1), .slave_2(slave_2),
    .dataout(dataout), .dout(dout), .respout(respout), .rdyout(rdyout),
    .Aout(Aout), .Dout(Dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "[TB] timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r1, input logic r2, input logic rw,
                               input logic rdy, input logic [1:0] rsp);
    busreq_1   = r1;
    busreq_2   = r2;
    read_write = rw;
    ready      = rdy;
    response   = rsp;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkAll(input vec_t e, input string tag);
    checkOutput({tag, ".grant_1"}, {31'd0, grant_1}, {31'd0, e.g1});
    checkOutput({tag, ".grant_2"}, {31'd0, grant_2}, {31'd0, e.g2});
    checkOutput({tag, ".address"}, {16'd0, address}, {16'd0, e.addr});
    checkOutput({tag, ".slave_sel"}, {29'd0, slave_2, slave_1, slave_0}, {29'd0, e.sel});
    checkOutput({tag, ".Aout"}, {31'd0, Aout}, {31'd0, e.aout});
    checkOutput({tag, ".Dout"}, {31'd0, Dout}, {31'd0, e.den});
    checkOutput({tag, ".dataout"}, dataout, e.wdata);
    if (e.chk_rd) begin
      checkOutput({tag, ".dout"}, dout, e.rd);
      checkOutput({tag, ".respout"}, {30'd0, respout}, {30'd0, e.rresp});
      checkOutput({tag, ".rdyout"}, {31'd0, rdyout}, {31'd0, e.rrdy});
    end
  endtask

  initial begin
    logic [15:0] dec_addr [2];
    logic [2:0]  dec_sel  [2];
    logic [31:0] dec_rd   [2];
    logic [1:0]  dec_resp [2];

    //             req1  req2  rw    rdy   resp   g1    g2    addr      sel     aout  den   wdata   chk   rd      rresp  rrdy
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 16'h0000, 3'b000, 1'b0, 1'b0, 32'd0,   1'b0, 32'd0,  2'b00, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 16'h2008, 3'b001, 1'b1, 1'b0, 32'd0,   1'b1, 32'd50, 2'b10, 1'b1};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 16'h2008, 3'b001, 1'b1, 1'b0, 32'd0,   1'b1, 32'd50, 2'b10, 1'b1};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 16'h0000, 3'b000, 1'b0, 1'b0, 32'd0,   1'b0, 32'd0,  2'b00, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 16'h0000, 3'b000, 1'b0, 1'b0, 32'd0,   1'b0, 32'd0,  2'b00, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 16'h4008, 3'b010, 1'b1, 1'b0, 32'd0,   1'b1, 32'd0,  2'b11, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 16'h4008, 3'b010, 1'b1, 1'b0, 32'd0,   1'b1, 32'd0,  2'b11, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 16'h0000, 3'b000, 1'b0, 1'b0, 32'd0,   1'b0, 32'd0,  2'b00, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 16'h0000, 3'b000, 1'b0, 1'b0, 32'd0,   1'b0, 32'd0,  2'b00, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 16'h2008, 3'b001, 1'b1, 1'b0, 32'd0,   1'b1, 32'd50, 2'b10, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 16'h2008, 3'b001, 1'b1, 1'b1, 32'd567, 1'b1, 32'd50, 2'b10, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 16'h0000, 3'b000, 1'b0, 1'b0, 32'd0,   1'b0, 32'd0,  2'b00, 1'b0};
    zero_v = '0;
    zero_v.chk_rd = 1'b1;

    dec_addr[0] = 16'h6000; dec_sel[0] = 3'b100; dec_rd[0] = 32'h333; dec_resp[0] = 2'b01;
    dec_addr[1] = 16'hE000; dec_sel[1] = 3'b000; dec_rd[1] = 32'h0;   dec_resp[1] = 2'b00;

    rst = 1'b1;
    split = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    data_in1 = 16'h2008; data_in2 = 16'h4008;
    data_in3 = 32'd567;  data_in4 = 32'hBEEF;
    rdin1 = 32'd50; rdin2 = 32'd0; rdin3 = 32'h333;
    resp1 = 2'b10;  resp2 = 2'b11; resp3 = 2'b01;
    rdy1 = 1'b1;    rdy2 = 1'b0;   rdy3 = 1'b1;

    #2;
    checkAll(zero_v, "reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].req1, vecs[i].req2, vecs[i].rw, vecs[i].rdy_in, vecs[i].resp_in);
      tick();
      checkAll(vecs[i], $sformatf("vec%0d", i));
    end

    // Wait states followed by a retry back to ADDR with the same owner.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 2'b00);
    tick(); tick(); tick();
    checkOutput("wait_enter.Dout", {31'd0, Dout}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("wait%0d.grant_1", i), {31'd0, grant_1}, 32'd1);
      checkOutput($sformatf("wait%0d.Dout", i), {31'd0, Dout}, 32'd1);
      checkOutput($sformatf("wait%0d.Aout", i), {31'd0, Aout}, 32'd1);
    end
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 2'b10);
    tick();
    checkOutput("retry_addr.grant_1", {31'd0, grant_1}, 32'd1);
    checkOutput("retry_addr.Aout", {31'd0, Aout}, 32'd1);
    checkOutput("retry_addr.Dout", {31'd0, Dout}, 32'd0);
    checkOutput("retry_addr.address", {16'd0, address}, 32'h2008);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 2'b00);
    tick();
    checkOutput("retry_data.Dout", {31'd0, Dout}, 32'd1);
    checkOutput("retry_data.dataout", dataout, 32'd567);
    tick();
    checkOutput("retry_done.grant_1", {31'd0, grant_1}, 32'd0);

    // SPLIT masks master 1 until a split pulse releases it.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 2'b11);
    tick();
    checkOutput("split_g.grant_1", {31'd0, grant_1}, 32'd1);
    tick(); tick(); tick();
    checkOutput("split_idle.grant_1", {31'd0, grant_1}, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 2'b00);
    tick();
    checkOutput("split_masked.grant_1", {31'd0, grant_1}, 32'd0);
    checkOutput("split_masked.grant_2", {31'd0, grant_2}, 32'd1);
    tick();
    checkOutput("split_masked.address", {16'd0, address}, 32'h4008);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
    tick();
    split = 1'b1;
    tick();
    split = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 2'b00);
    tick();
    checkOutput("split_release.grant_1", {31'd0, grant_1}, 32'd1);
    checkOutput("split_release.grant_2", {31'd0, grant_2}, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
    tick(); tick(); tick();

    // Decode of slave 2 and of an unmapped region.
    for (int i = 0; i < 2; i++) begin
      data_in1 = dec_addr[i];
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 2'b00);
      tick(); tick();
      checkOutput($sformatf("dec%0d.sel", i), {29'd0, slave_2, slave_1, slave_0}, {29'd0, dec_sel[i]});
      checkOutput($sformatf("dec%0d.address", i), {16'd0, address}, {16'd0, dec_addr[i]});
      checkOutput($sformatf("dec%0d.dout", i), dout, dec_rd[i]);
      checkOutput($sformatf("dec%0d.respout", i), {30'd0, respout}, {30'd0, dec_resp[i]});
      checkOutput($sformatf("dec%0d.rdyout", i), {31'd0, rdyout}, 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
      tick(); tick();
    end
    data_in1 = 16'h2008;

    // Asynchronous reset in the middle of a write data phase.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 2'b00);
    tick(); tick(); tick();
    checkOutput("pre_reset.dataout", dataout, 32'd567);
    #3;
    rst = 1'b1;
    #1;
    checkAll(zero_v, "async_reset");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 2'b00);
    #2;
    rst = 1'b0;
    tick();
    checkOutput("post_reset.grant_1", {31'd0, grant_1}, 32'd0);
    checkOutput("post_reset.Aout", {31'd0, Aout}, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 2'b00);
    tick();
    checkOutput("post_reset_grant.grant_1", {31'd0, grant_1}, 32'd1);
    checkOutput("post_reset_grant.Aout", {31'd0, Aout}, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
    tick(); tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ahb_bus_fabric.md
Name: ahb_bus_fabric

Overview:
- Simplified single-transfer AHB-style interconnect: two masters, three slaves.
- Arbiter FSM grants the bus, with master 1 having fixed priority.
- Selected master's address is registered, decoded into one of three slave selects, and placed on the shared address bus.
- Write data is muxed from the granted master to the slaves; read data, response and ready are muxed from the selected slave back to the masters.

Parameters:
- AW, 16, address width.
- DW, 32, data width.

Ports:
- clk in 1: rising-edge clock.
- rst in 1: asynchronous, active-high reset.
- busreq_1 in 1: bus request, master 1.
- busreq_2 in 1: bus request, master 2.
- read_write in 1: transfer direction of the granted master; 1 = write, 0 = read.
- ready in 1: slave ready seen by the arbiter.
- response in 2: slave response seen by the arbiter; 00 OKAY, 01 ERROR, 10 RETRY, 11 SPLIT.
- split in 1: split-release pulse from a slave.
- data_in1 in AW: address, master 1.
- data_in2 in AW: address, master 2.
- data_in3 in DW: write data, master 1.
- data_in4 in DW: write data, master 2.
- rdin1, rdin2, rdin3 in DW each: read data, slaves 0, 1, 2.
- resp1, resp2, resp3 in 2 each: response, slaves 0, 1, 2.
- rdy1, rdy2, rdy3 in 1 each: ready, slaves 0, 1, 2.
- grant_1 out 1: grant to master 1.
- grant_2 out 1: grant to master 2.
- address out AW: shared address bus.
- slave_0, slave_1, slave_2 out 1 each: one-hot slave selects.
- dataout out DW: write data to slaves.
- dout out DW: read data to masters.
- respout out 2: muxed slave response.
- rdyout out 1: muxed slave ready.
- Aout out 1: address-phase enable.
- Dout out 1: write-data-phase enable.

Behaviour:
- Reset (rst=1, asynchronous):
  - State goes to IDLE.
  - All outputs are 0.
  - Both split masks are cleared.
- FSM states: IDLE, GRANT, ADDR, DATA. All registered on clk.
- IDLE:
  - Outputs grant_1 = grant_2 = Aout = Dout = 0.
  - If unmasked busreq_1: record owner = M1, go to GRANT.
  - Else if unmasked busreq_2: owner = M2, go to GRANT.
  - Else stay in IDLE.
  - Simultaneous requests: M1 wins.
- GRANT:
  - grant_1 or grant_2 = 1 according to owner; the grant stays asserted through ADDR and DATA.
  - Next state is ADDR.
- ADDR:
  - Address register loads the owner's address (data_in1 or data_in2); Aout = 1.
  - Slave select decodes combinationally from the address register, using address[15:13]: 001 → slave_0, 010 → slave_1, 011 → slave_2, any other value → no slave.
  - Next state is DATA.
- DATA:
  - Aout stays 1.
  - If read_write = 1: Dout = 1 and dataout = owner's write data (data_in3 or data_in4).
  - If read_write = 0: dataout = 0 and Dout = 0.
  - dout, respout and rdyout always reflect the selected slave's rdin/resp/rdy. With no slave selected: dout = 0, respout = 00, rdyout = 1.
  - ready = 0: stay in DATA (wait states, unbounded).
  - ready = 1 with response 00 (OKAY) or 01 (ERROR): drop the grant, go to IDLE.
  - ready = 1 with response 10 (RETRY): keep the grant, return to ADDR.
  - ready = 1 with response 11 (SPLIT): set the owner's split mask, drop the grant, go to IDLE.
- Split masks:
  - A masked master's busreq is ignored by the arbiter.
  - split = 1 on any clock edge clears both masks.
  - If a mask is set and cleared in the same cycle, the clear wins.
- Outside ADDR/DATA: address = 0 and all slave selects = 0; the address register holds its last value internally.
- Outside DATA: dataout = 0. dout, respout and rdyout follow the decoded selection at all times.
- busreq deasserted mid-transfer is ignored; the transfer completes.
- Reset asserted mid-transfer aborts it immediately; all outputs go to 0.

Test Plan:
- Priority read: rst 1→0; busreq_1 = busreq_2 = 1, read_write = 0, ready = 1, response = 00, data_in1 = 0x2008, rdin1 = 50, resp1 = 10, rdy1 = 1.
  - Expect grant_1 = 1 (grant_2 = 0) one cycle after IDLE, then address = 0x2008 and slave_0 = 1.
  - Expect dout = 50, respout = 10, rdyout = 1, then return to IDLE.
- M2 read: busreq_2 only, data_in2 = 0x4008, rdin2 = 0, resp2 = 11, rdy2 = 0.
  - Expect grant_2 = 1, slave_1 = 1, dout = 0, respout = 11, rdyout = 0.
- M1 write: busreq_1 = 1, read_write = 1, data_in3 = 567.
  - Expect Dout = 1 and dataout = 567 in DATA; Aout = 1 in ADDR and DATA.
- Wait/retry: hold ready = 0 for 3 cycles → FSM stays in DATA with the grant held. Then ready = 1 with response = 10 → re-enters ADDR with the same owner.
- Split:
  - response = 11 with ready = 1 while M1 owns the bus, both masters requesting → M1 masked; next grant goes to M2.
  - Pulse split = 1 → M1 wins again.
- Async reset: assert rst mid-DATA between clock edges → all outputs 0 immediately, state IDLE.
